uart_receiver: RTL and testbench

UART receive path, the counterpart of the team's `transmitter` block on the same serial link. It samples the asynchronous `rx` line, recovers 8N1 frames at a fixed baud rate, and delivers each byte as a one-cycle `valid` pulse. It reports line faults (framing, and optionally parity) to the host-side logic on the same 100 MHz clock domain.

---
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_receiver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive path with a 2-flop input synchronizer and mid-bit sampling.
// 8N1 by default; define UART_RX_PARITY_EN for 8E1 frames with parity_err reporting.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_n;
    logic             rx_p0, rx_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             valid_n, frame_err_n, parity_err_n;
    logic             par_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_p0      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_p0      <= rx;
            rx_s       <= rx_p0;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            data       <= data_n;
            valid      <= valid_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_n;
        end
    end

    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_ONE;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        data_n       = data;
        valid_n      = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n    = par_err_q;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                end
            end
            // Half a bit into the start bit; a high line here was only a glitch.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_err_n = rx_s ^ (^shift);
                    state_n   = STOP;
                end
            end
`endif
            // Leaving at mid-stop-bit gives half a bit of margin for a back-to-back start.
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                        if (par_bad) begin
                            parity_err_n = 1'b1;
                        end else begin
                            valid_n = 1'b1;
                            data_n  = shift;
                        end
                    end else begin
                        state_n      = WAIT_HIGH;
                        frame_err_n  = 1'b1;
                        parity_err_n = par_bad;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level timing model, checked every cycle.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the 8E1 variant.
module tb_uart_receiver;
    localparam int C        = 868;
    localparam int H        = C / 2;
    localparam int SYNC_LAT = 3;            // rx change after edge N is acted on at edge N+3
`ifdef UART_RX_PARITY_EN
    localparam int SPAN     = 10;           // bit periods from start-bit centre to stop-bit centre
    localparam int LAT_LIT  = 9117;         // 3 + 434 + 10*868
    localparam int GAP_LIT  = 9548;         // 11 * 868
`else
    localparam int SPAN     = 9;
    localparam int LAT_LIT  = 8249;         // 3 + 434 + 9*868
    localparam int GAP_LIT  = 8680;         // 10 * 868
`endif
    localparam int OPEN     = 32'h7fff_ffff;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err, parity_err;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int   cyc      = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    typedef struct { int edge_c; logic v; logic fe; logic pe; logic [7:0] b; } ev_t;
    typedef struct { int s; int e; } iv_t;
    ev_t ev_q[$];
    iv_t iv_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         vcyc_q[$];
    logic [7:0] vdat_q[$];
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         fall_cyc = -1;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected outcome of one frame whose start edge is driven just after edge tf.
    task automatic model_frame(input int tf, input logic [7:0] b, input logic stop_bit,
                               input logic par_bit);
        ev_t  x;
        iv_t  iv;
        logic bad;
        int   t0;
        t0 = tf + SYNC_LAT;
`ifdef UART_RX_PARITY_EN
        bad = (par_bit != even_par(b));
`else
        bad = 1'b0 & par_bit;
`endif
        x.edge_c = t0 + H + SPAN * C;
        x.b      = b;
        x.v      = stop_bit && !bad;
        x.fe     = !stop_bit;
        x.pe     = bad;
        ev_q.push_back(x);
        iv.s = t0;
        iv.e = stop_bit ? x.edge_c : OPEN;
        iv_q.push_back(iv);
    endtask

    task automatic model_glitch(input int tf);
        iv_t iv;
        iv.s = tf + SYNC_LAT;
        iv.e = tf + SYNC_LAT + H;
        iv_q.push_back(iv);
    endtask

    task automatic model_rise(input int tr);
        foreach (iv_q[i]) if (iv_q[i].e == OPEN) iv_q[i].e = tr + SYNC_LAT;
    endtask

    // Called at posedge+1; holds rx for n edges and returns at posedge+1.
    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        model_frame(cyc, b, stop_bit, par_bit);
        line(1'b0, C);
        for (int k = 0; k < 8; k++) line(b[k], C);
`ifdef UART_RX_PARITY_EN
        line(par_bit, C);
`endif
        line(stop_bit, C);
    endtask

    initial begin : compare
        logic [11:0] act, exp;
        logic        e_v, e_fe, e_pe, e_busy, prev_busy;
        logic [7:0]  e_data;
        e_data    = 8'h00;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                e_v = 1'b0; e_fe = 1'b0; e_pe = 1'b0; e_busy = 1'b0;
                if (!rst_seen) begin
                    e_data = 8'h00;
                    for (int i = ev_q.size() - 1; i >= 0; i--)
                        if (ev_q[i].edge_c >= cyc) ev_q.delete(i);
                    foreach (iv_q[i]) if (iv_q[i].e > cyc) iv_q[i].e = cyc;
                end else begin
                    foreach (ev_q[i]) begin
                        if (ev_q[i].edge_c == cyc) begin
                            if (ev_q[i].v) begin
                                e_v    = 1'b1;
                                e_data = ev_q[i].b;
                            end
                            if (ev_q[i].fe) e_fe = 1'b1;
                            if (ev_q[i].pe) e_pe = 1'b1;
                        end
                    end
                    foreach (iv_q[i]) if (iv_q[i].s <= cyc && cyc < iv_q[i].e) e_busy = 1'b1;
                end
                act = {busy, valid, frame_err, parity_err, data};
                exp = {e_busy, e_v, e_fe, e_pe, e_data};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cycle %0d busy/valid/ferr/perr/data: got %b %b %b %b %02h, want %b %b %b %b %02h",
                             cyc, busy, valid, frame_err, parity_err, data,
                             e_busy, e_v, e_fe, e_pe, e_data);
                end
                if (valid === 1'b1) begin
                    vcyc_q.push_back(cyc);
                    vdat_q.push_back(data);
                end
                if (frame_err === 1'b1) fe_cnt++;
                if (parity_err === 1'b1) pe_cnt++;
                if (prev_busy && busy === 1'b0) fall_cyc = cyc;
                prev_busy = (busy === 1'b1);
            end
        end
    end

    initial begin : stim
        int         tf, tr, v0, fe0, pe0;
        logic [7:0] b3c;
        b3c   = 8'h3C;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset data", int'(data), 0);
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(valid), 0);
        rst_n = 1'b1;
        line(1'b1, 20);

        // 0xFF then 0x00 with no idle gap
        v0 = vcyc_q.size();
        send_frame(8'hFF, 1'b1, even_par(8'hFF));
        send_frame(8'h00, 1'b1, even_par(8'h00));
        line(1'b1, 50);
        check("b2b valid count", vcyc_q.size() - v0, 2);
        if (vcyc_q.size() >= v0 + 2) begin
            check("b2b pulse gap", vcyc_q[v0+1] - vcyc_q[v0], GAP_LIT);
            check("b2b first data", int'(vdat_q[v0]), 8'hFF);
            check("b2b second data", int'(vdat_q[v0+1]), 8'h00);
        end

        // single 0x55
        v0 = vcyc_q.size(); fe0 = fe_cnt;
        tf = cyc;
        send_frame(8'h55, 1'b1, even_par(8'h55));
        line(1'b1, 50);
        check("0x55 valid count", vcyc_q.size() - v0, 1);
        if (vcyc_q.size() >= v0 + 1) check("0x55 valid latency", vcyc_q[v0] - tf, LAT_LIT);
        check("0x55 data", int'(data), 8'h55);
        check("0x55 busy after", int'(busy), 0);
        check("0x55 no frame_err", fe_cnt - fe0, 0);

        // 200-cycle low glitch
        v0 = vcyc_q.size(); fe0 = fe_cnt;
        tf = cyc;
        model_glitch(tf);
        line(1'b0, 200);
        line(1'b1, 600);
        check("glitch no valid", vcyc_q.size() - v0, 0);
        check("glitch no frame_err", fe_cnt - fe0, 0);
        check("glitch busy fall", fall_cyc - tf, 437);

        // 0xA5 with low stop bit, then a held break
        v0 = vcyc_q.size(); fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0, even_par(8'hA5));
        line(1'b0, 20000);
        check("break busy held", int'(busy), 1);
        tr = cyc;
        model_rise(tr);
        line(1'b1, 100);
        check("break frame_err count", fe_cnt - fe0, 1);
        check("break no valid", vcyc_q.size() - v0, 0);
        check("break data kept", int'(data), 8'h55);
        check("break busy fall", fall_cyc - tr, 3);

        // reset in the middle of bit 4 of 0x3C; the rest of the frame is abandoned
        v0 = vcyc_q.size(); fe0 = fe_cnt;
        model_frame(cyc, b3c, 1'b1, even_par(b3c));
        line(1'b0, C);
        for (int k = 0; k < 4; k++) line(b3c[k], C);
        line(b3c[4], H);
        rst_n = 1'b0;
        line(b3c[4], 3);
        check("midreset data", int'(data), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset valid", int'(valid), 0);
        rst_n = 1'b1;
        line(1'b1, 300);
        check("midreset no valid", vcyc_q.size() - v0, 0);
        check("midreset no frame_err", fe_cnt - fe0, 0);

        // 0xC3 after the reset
        v0 = vcyc_q.size();
        send_frame(8'hC3, 1'b1, even_par(8'hC3));
        line(1'b1, 50);
        check("0xC3 valid count", vcyc_q.size() - v0, 1);
        check("0xC3 data", int'(data), 8'hC3);

`ifdef UART_RX_PARITY_EN
        v0 = vcyc_q.size(); pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        line(1'b1, 50);
        check("par good valid count", vcyc_q.size() - v0, 1);
        check("par good data", int'(data), 8'h07);
        check("par good no parity_err", pe_cnt - pe0, 0);
        v0 = vcyc_q.size(); pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        line(1'b1, 50);
        check("par bad no valid", vcyc_q.size() - v0, 0);
        check("par bad parity_err count", pe_cnt - pe0, 1);
        check("par bad data kept", int'(data), 8'h07);
`else
        pe0 = 0;
        check("no parity_err ever", pe_cnt - pe0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
